// File: rtl/riscoffee_uart_tx.sv
// ---------------------------------------------------------------------------
// riscoffee_uart_tx
//
// Memory-mapped UART transmitter on the MA-stage data bus. Byte stores to
// TXDATA are queued in a small circular FIFO and shifted out 8N1 (LSB
// first) on TXD. A STATUS register exposes the queue fill level, the
// transmitter busy flag and a sticky overflow flag for software polling.
//
// Register map (MA_ADDR[31:3] must equal BASE_ADDR[31:3]):
//   +0 TXDATA  write: queue MA_WDATA[7:0]        read: 0
//   +4 STATUS  write: MA_WDATA[3]=1 clears OVF   read: {16'b0, count[7:0],
//                                                  4'b0, ovf, busy, empty, full}
//
// Parameters:
//   CLK_DIV    clock cycles per serial bit (>= 2)
//   DEPTH      FIFO entries (power of two, >= 2)
//   BASE_ADDR  block base address (8-byte aligned)
//
// Ports:
//   CLK       clock, all state changes on the rising edge
//   RST_N     asynchronous active-low reset
//   MA_WEN    store valid from the MA stage
//   MA_REN    load valid from the MA stage
//   MA_ADDR   byte address of the access
//   MA_WDATA  store data
//   MA_RDATA  registered load data, valid the cycle after MA_REN
//   TXD       serial output, idle high, always driven from a flop
//   TX_FULL   FIFO holds DEPTH entries
// ---------------------------------------------------------------------------
module riscoffee_uart_tx #(
  parameter int unsigned CLK_DIV   = 868,
  parameter int unsigned DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'hF000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        MA_WEN,
  input  logic        MA_REN,
  input  logic [31:0] MA_ADDR,
  input  logic [31:0] MA_WDATA,
  output logic [31:0] MA_RDATA,
  output logic        TXD,
  output logic        TX_FULL
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(CLK_DIV);

  localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Bus decode
  logic          hit;
  logic          sel_status;
  logic          wr_data_hit;
  logic          wr_status_hit;
  logic          rd_hit;

  // FIFO
  logic [7:0]    fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic          ovf;

  // Transmitter
  tx_state_t     state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    sh;

  // Status word
  logic          busy;
  logic          empty;
  logic [7:0]    count8;
  logic [31:0]   status_word;

  // Address bits below the word and the upper store-data bits carry no
  // meaning for this block; fold them together so they are visibly consumed.
  logic          unused_ma_bits;
  assign unused_ma_bits = ^{MA_ADDR[1:0], MA_WDATA[31:8]};

  assign hit           = (MA_ADDR[31:3] == BASE_ADDR[31:3]);
  assign sel_status    = MA_ADDR[2];
  assign wr_data_hit   = hit && MA_WEN && !sel_status;
  assign wr_status_hit = hit && MA_WEN &&  sel_status;
  assign rd_hit        = hit && MA_REN;

  // A push into a full FIFO is dropped even when the transmitter pops in the
  // same cycle, so "full" is judged on the pre-edge count only.
  assign TX_FULL = (count == FULL_COUNT);
  assign push    = wr_data_hit && !TX_FULL;
  assign pop     = (state == IDLE) && (count != '0);

  assign busy        = (state != IDLE);
  assign empty       = (count == '0);
  assign count8      = 8'(count);
  assign status_word = {16'h0000, count8, 4'h0, ovf, busy, empty, TX_FULL};

  // FIFO storage has no reset: after reset the pointers and count mark it
  // empty, so stale contents can never be popped.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= MA_WDATA[7:0];
    end
  end

  // Pointers wrap naturally at DEPTH; the extra count bit distinguishes
  // full from empty. Simultaneous push and pop leave the count unchanged.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: set by a dropped TXDATA byte, cleared by software
  // writing bit 3 of STATUS. Both cannot happen in one cycle since a single
  // store selects only one register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovf <= 1'b0;
    end else if (wr_data_hit && !push) begin
      ovf <= 1'b1;
    end else if (wr_status_hit && MA_WDATA[3]) begin
      ovf <= 1'b0;
    end
  end

  // Load data is registered from pre-edge state, so a load issued together
  // with a store observes the state before that store.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      MA_RDATA <= '0;
    end else if (rd_hit && sel_status) begin
      MA_RDATA <= status_word;
    end else begin
      MA_RDATA <= '0;
    end
  end

  // Transmit FSM. TXD is loaded with the level of the state being entered,
  // so the line changes on the same edge as the state and stays glitch-free.
  // Every bit (start, 8 data, stop) lasts CLK_DIV cycles; after STOP the FSM
  // spends exactly one cycle in IDLE before popping the next byte.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      sh       <= '0;
      TXD      <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          TXD <= 1'b1;
          if (pop) begin
            sh       <= fifo_mem[rd_ptr];
            baud_cnt <= BAUD_RELOAD;
            state    <= START;
            TXD      <= 1'b0;
          end
        end

        START: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_RELOAD;
            bit_idx  <= '0;
            state    <= DATA;
            TXD      <= sh[0];
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end

        DATA: begin
          if (baud_cnt == '0) begin
            sh       <= {1'b0, sh[7:1]};
            baud_cnt <= BAUD_RELOAD;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              TXD   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              TXD     <= sh[1];
            end
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end

        STOP: begin
          if (baud_cnt == '0) begin
            state <= IDLE;
            TXD   <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end

        default: begin
          state <= IDLE;
          TXD   <= 1'b1;
        end
      endcase
    end
  end

endmodule
